bus_arbiter_ctrl: RTL and testbench

Central controller for the shared bit-serial bus that connects the bus masters to the memory-mapped slaves, such as the 2K slave.
- Arbitrates between NUM_MASTERS requesters using round-robin.
- Captures the granted master's 16-bit serial address and decodes the target slave from it.
- Replays the address to that slave with B_UTIL asserted, then routes data and ACKs until the master releases the bus.
- Flags an error if the slave never acknowledges within the timeout.

---
 rtl/bus_pkg.sv | 21 ++
 rtl/bus_arbiter_ctrl_rr.sv | 31 +++
 rtl/bus_arbiter_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_bus_arbiter_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the bit-serial bus controller.
//   bus_state_t : controller FSM states
//   ADDR_W      : width of the serial address phase
//   BUS_READ / BUS_WRITE : encoding of the transfer direction bit
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPT    = 3'd1,
    FWD     = 3'd2,
    WAITACK = 3'd3,
    XFER    = 3'd4,
    RLS     = 3'd5
  } bus_state_t;

  localparam int unsigned ADDR_W = 16;

  localparam logic BUS_READ  = 1'b1;
  localparam logic BUS_WRITE = 1'b0;

endpackage

// File: rtl/bus_arbiter_ctrl_rr.sv
// Combinational round-robin pick.
//   req   : per-requester level request
//   ptr   : index of the last owner; search starts at ptr+1 and wraps
//   grant : one-hot winner (zero when nothing requests)
//   valid : at least one request present
module rr_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             valid
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PTR_W'((32'(ptr) + 1 + i) % N);
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_ctrl.sv
// Central controller of the shared bit-serial bus.
//   CLK, RSTN           : clock, asynchronous active-low reset
//   REQ / GNT           : per-master level request, registered one-hot grant
//   MST_VALID/BIT/RW    : serial address/data and direction from the masters
//   MST_RDBIT/ACK/ERR   : read data, forwarded ACK, error pulse to the owner
//   B_UTIL/B_RW         : one-hot slave select and direction to the slaves
//   B_BUS_OUT           : serial bit to the slaves (address replay, then data)
//   B_BUS_IN / B_ACK    : per-slave serial data and acknowledge
module bus_arbiter_ctrl
  import bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned NUM_SLAVES  = 3,
  parameter int unsigned SEL_LSB     = 11,
  parameter int unsigned SEL_W       = 2,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic [NUM_MASTERS-1:0] REQ,
  output logic [NUM_MASTERS-1:0] GNT,
  input  logic [NUM_MASTERS-1:0] MST_VALID,
  input  logic [NUM_MASTERS-1:0] MST_BIT,
  input  logic [NUM_MASTERS-1:0] MST_RW,
  output logic                   MST_RDBIT,
  output logic                   MST_ACK,
  output logic                   MST_ERR,
  output logic [NUM_SLAVES-1:0]  B_UTIL,
  output logic                   B_RW,
  output logic                   B_BUS_OUT,
  input  logic [NUM_SLAVES-1:0]  B_BUS_IN,
  input  logic [NUM_SLAVES-1:0]  B_ACK
);

  localparam int unsigned MW      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned CNT_MAX = (ADDR_W > ACK_TIMEOUT) ? ADDR_W : ACK_TIMEOUT;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  bus_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [MW-1:0]          gidx_q, gidx_d;
  logic [MW-1:0]          ptr_q, ptr_d;
  logic                   rw_q, rw_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [NUM_SLAVES-1:0]  b_util_q, b_util_d;
  logic                   b_rw_q, b_rw_d;
  logic                   err_q, err_d;
  logic                   ack_first_q, ack_first_d;

  logic [NUM_MASTERS-1:0] win_oh;
  logic                   win_valid;
  logic [MW-1:0]          win_idx;
  logic [ADDR_W-1:0]      addr_shift;
  logic [SEL_W-1:0]       sel_new;
  logic                   req_own;
  logic                   to_rls;
  logic                   timeout_err;

  rr_arbiter #(
    .N     (NUM_MASTERS),
    .PTR_W (MW)
  ) u_rr (
    .req   (REQ),
    .ptr   (ptr_q),
    .grant (win_oh),
    .valid (win_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (win_oh[i]) win_idx = MW'(i);
    end
  end

  assign addr_shift = {addr_q[ADDR_W-2:0], MST_BIT[gidx_q]};
  assign sel_new    = addr_shift[SEL_LSB +: SEL_W];
  assign req_own    = REQ[gidx_q];

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gidx_d      = gidx_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    b_util_d    = b_util_q;
    b_rw_d      = b_rw_q;
    err_d       = 1'b0;
    ack_first_d = 1'b0;
    to_rls      = 1'b0;
    timeout_err = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          gnt_d   = win_oh;
          gidx_d  = win_idx;
          rw_d    = MST_RW[win_idx];
          addr_d  = '0;
          cnt_d   = '0;
          state_d = CAPT;
        end
      end
      CAPT: begin
        if (!req_own) begin
          to_rls = 1'b1;
        end else if (MST_VALID[gidx_q]) begin
          addr_d = addr_shift;
          if (cnt_q == CNT_W'(ADDR_W - 1)) begin
            cnt_d = '0;
            // Decode uses the just-completed address, so check the shifted value.
            if (32'(sel_new) >= NUM_SLAVES) begin
              err_d  = 1'b1;
              to_rls = 1'b1;
            end else begin
              sel_d            = sel_new;
              b_util_d         = '0;
              b_util_d[sel_new] = 1'b1;
              b_rw_d           = rw_q;
              state_d          = FWD;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FWD: begin
        if (!req_own) begin
          to_rls = 1'b1;
        end else begin
          addr_d = {addr_q[ADDR_W-2:0], 1'b0};
          if (cnt_q == CNT_W'(ADDR_W - 1)) begin
            cnt_d   = '0;
            state_d = WAITACK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WAITACK: begin
        if (!req_own) begin
          to_rls = 1'b1;
        end else if (B_ACK[sel_q]) begin
          ack_first_d = 1'b1;
          state_d     = XFER;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          // Error is flagged during the final waiting cycle itself.
          timeout_err = 1'b1;
          to_rls      = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      XFER: begin
        if (!req_own) to_rls = 1'b1;
      end
      RLS: begin
        ptr_d   = gidx_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (to_rls) begin
      state_d  = RLS;
      gnt_d    = '0;
      b_util_d = '0;
      b_rw_d   = BUS_WRITE;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gidx_q      <= '0;
      ptr_q       <= MW'(NUM_MASTERS - 1);
      rw_q        <= BUS_WRITE;
      addr_q      <= '0;
      cnt_q       <= '0;
      sel_q       <= '0;
      b_util_q    <= '0;
      b_rw_q      <= BUS_WRITE;
      err_q       <= 1'b0;
      ack_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gidx_q      <= gidx_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      b_util_q    <= b_util_d;
      b_rw_q      <= b_rw_d;
      err_q       <= err_d;
      ack_first_q <= ack_first_d;
    end
  end

  assign GNT    = gnt_q;
  assign B_UTIL = b_util_q;
  assign B_RW   = b_rw_q;

  // ack_first_q keeps MST_ACK high on XFER entry even if the slave only pulsed ACK.
  assign MST_ACK   = (state_q == XFER) && (B_ACK[sel_q] || ack_first_q);
  assign MST_RDBIT = (state_q == XFER) && B_BUS_IN[sel_q];
  assign MST_ERR   = err_q || timeout_err;

  always_comb begin
    B_BUS_OUT = 1'b0;
    if (state_q == FWD)  B_BUS_OUT = addr_q[ADDR_W-1];
    if (state_q == XFER) B_BUS_OUT = MST_BIT[gidx_q];
  end

endmodule

// File: tb/tb_bus_arbiter_ctrl.sv
module tb_bus_arbiter_ctrl;
  import bus_pkg::*;

  logic       CLK;
  logic       RSTN;
  logic [1:0] REQ, GNT, MST_VALID, MST_BIT, MST_RW;
  logic       MST_RDBIT, MST_ACK, MST_ERR;
  logic [2:0] B_UTIL, B_BUS_IN, B_ACK;
  logic       B_RW, B_BUS_OUT;

  int chk_pass;
  int chk_total;

  bus_arbiter_ctrl #(
    .NUM_MASTERS (2),
    .NUM_SLAVES  (3),
    .SEL_LSB     (11),
    .SEL_W       (2),
    .ACK_TIMEOUT (16)
  ) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .REQ       (REQ),
    .GNT       (GNT),
    .MST_VALID (MST_VALID),
    .MST_BIT   (MST_BIT),
    .MST_RW    (MST_RW),
    .MST_RDBIT (MST_RDBIT),
    .MST_ACK   (MST_ACK),
    .MST_ERR   (MST_ERR),
    .B_UTIL    (B_UTIL),
    .B_RW      (B_RW),
    .B_BUS_OUT (B_BUS_OUT),
    .B_BUS_IN  (B_BUS_IN),
    .B_ACK     (B_ACK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Master 0 shifts a 16-bit address MSB first; optional idle cycle mid-way.
  task automatic send_addr(input logic [15:0] a, input bit gap);
    logic [15:0] sh;
    sh = a;
    for (int i = 0; i < 16; i++) begin
      if (gap && i == 8) begin
        MST_VALID[0] = 1'b0;
        MST_BIT[0]   = 1'b1;
        step();
      end
      MST_VALID[0] = 1'b1;
      MST_BIT[0]   = sh[15];
      sh           = sh << 1;
      step();
    end
    MST_VALID[0] = 1'b0;
    MST_BIT[0]   = 1'b0;
  endtask

  task automatic test_reset();
    RSTN = 1'b0; REQ = '0; MST_VALID = '0; MST_BIT = '0; MST_RW = '0;
    B_BUS_IN = '0; B_ACK = '0;
    step(); step();
    chk_total++;
    if ({GNT, B_UTIL, B_RW, B_BUS_OUT, MST_RDBIT, MST_ACK, MST_ERR} !== 10'b0) begin
      $display("FAIL reset_outputs: got %b expected 0", {GNT, B_UTIL, B_RW, B_BUS_OUT, MST_RDBIT, MST_ACK, MST_ERR});
    end else chk_pass++;
    #2 RSTN = 1'b1;
    step();
    chk_total++;
    if (GNT !== 2'b00) $display("FAIL idle_no_req_gnt: got %b expected 00", GNT);
    else chk_pass++;
  endtask

  task automatic test_write_basic();
    logic [15:0] got;
    logic [1:0]  pass_bits;
    REQ = 2'b01; MST_RW = {1'b0, BUS_WRITE};
    step();
    chk_total++;
    if (GNT !== 2'b01) $display("FAIL wr_gnt: got %b expected 01", GNT);
    else chk_pass++;
    send_addr(16'h0812, 1'b1);
    chk_total++;
    if ({B_UTIL, B_RW} !== 4'b010_0) $display("FAIL wr_util_rw: got %b expected 0100", {B_UTIL, B_RW});
    else chk_pass++;
    got = '0;
    for (int i = 0; i < 16; i++) begin
      got = {got[14:0], B_BUS_OUT};
      step();
    end
    chk_total++;
    if (got !== 16'h0812) $display("FAIL wr_replay: got %h expected 0812", got);
    else chk_pass++;
    B_ACK = 3'b010;
    #1;
    chk_total++;
    if (MST_ACK !== 1'b0) $display("FAIL wr_ack_waitack: got %b expected 0", MST_ACK);
    else chk_pass++;
    step();
    chk_total++;
    if (MST_ACK !== 1'b1) $display("FAIL wr_ack_xfer: got %b expected 1", MST_ACK);
    else chk_pass++;
    MST_BIT[0] = 1'b1; #1 pass_bits[1] = B_BUS_OUT;
    MST_BIT[0] = 1'b0; #1 pass_bits[0] = B_BUS_OUT;
    chk_total++;
    if (pass_bits !== 2'b10) $display("FAIL wr_data_pass: got %b expected 10", pass_bits);
    else chk_pass++;
    REQ = 2'b00; B_ACK = '0;
    step();
    chk_total++;
    if ({GNT, B_UTIL, MST_ACK} !== 6'b0) $display("FAIL wr_rls: got %b expected 0", {GNT, B_UTIL, MST_ACK});
    else chk_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    #1 RSTN = 1'b0;
    #2 RSTN = 1'b1;
    REQ = 2'b11;
    step();
    chk_total++;
    if (GNT !== 2'b01) $display("FAIL rr_first: got %b expected 01", GNT);
    else chk_pass++;
    step(); step();
    REQ = 2'b10;
    step();
    chk_total++;
    if (GNT !== 2'b00) $display("FAIL rr_rls0: got %b expected 00", GNT);
    else chk_pass++;
    REQ = 2'b11;
    step();
    chk_total++;
    if (GNT !== 2'b00) $display("FAIL rr_idle0: got %b expected 00", GNT);
    else chk_pass++;
    step();
    chk_total++;
    if (GNT !== 2'b10) $display("FAIL rr_second: got %b expected 10", GNT);
    else chk_pass++;
    REQ = 2'b10; step();
    REQ = 2'b11; step();
    chk_total++;
    if (GNT !== 2'b10) $display("FAIL rr_no_preempt: got %b expected 10", GNT);
    else chk_pass++;
    REQ = 2'b01;
    step();
    REQ = 2'b11;
    step(); step();
    chk_total++;
    if (GNT !== 2'b01) $display("FAIL rr_third: got %b expected 01", GNT);
    else chk_pass++;
    REQ = 2'b00;
    step(); step();
  endtask

  task automatic test_decode_err();
    REQ = 2'b01;
    step();
    send_addr(16'h1800, 1'b0);
    chk_total++;
    if ({MST_ERR, GNT, B_UTIL} !== 6'b1_00_000) $display("FAIL dec_err_rls: got %b expected 100000", {MST_ERR, GNT, B_UTIL});
    else chk_pass++;
    REQ = 2'b00;
    step();
    chk_total++;
    if ({MST_ERR, GNT} !== 3'b000) $display("FAIL dec_err_pulse: got %b expected 000", {MST_ERR, GNT});
    else chk_pass++;
  endtask

  task automatic test_timeout();
    bit early;
    REQ = 2'b01;
    step();
    send_addr(16'h0812, 1'b0);
    for (int i = 0; i < 16; i++) step();
    early = 1'b0;
    for (int c = 1; c < 16; c++) begin
      if (MST_ERR !== 1'b0) early = 1'b1;
      step();
    end
    chk_total++;
    if (early) $display("FAIL to_early: got 1 expected 0");
    else chk_pass++;
    chk_total++;
    if (MST_ERR !== 1'b1) $display("FAIL to_err16: got %b expected 1", MST_ERR);
    else chk_pass++;
    step();
    chk_total++;
    if ({MST_ERR, GNT, B_UTIL} !== 6'b0) $display("FAIL to_rls: got %b expected 0", {MST_ERR, GNT, B_UTIL});
    else chk_pass++;
    REQ = 2'b00;
    step();
    step();
    chk_total++;
    if (GNT !== 2'b00) $display("FAIL to_idle: got %b expected 00", GNT);
    else chk_pass++;
  endtask

  task automatic test_read_slave2();
    logic [3:0] pat;
    logic [3:0] got;
    logic [3:0] sh;
    REQ = 2'b01; MST_RW = {1'b0, BUS_READ};
    step();
    send_addr(16'h1000, 1'b0);
    chk_total++;
    if ({B_UTIL, B_RW} !== 4'b100_1) $display("FAIL rd_util_rw: got %b expected 1001", {B_UTIL, B_RW});
    else chk_pass++;
    for (int i = 0; i < 16; i++) step();
    B_ACK = 3'b100;
    step();
    pat = 4'b1011;
    sh  = pat;
    got = '0;
    for (int i = 0; i < 4; i++) begin
      B_BUS_IN = {sh[3], ~sh[3], 1'b0};
      sh = sh << 1;
      #1 got = {got[2:0], MST_RDBIT};
      step();
    end
    chk_total++;
    if (got !== 4'b1011) $display("FAIL rd_mirror: got %b expected 1011", got);
    else chk_pass++;
    B_BUS_IN = 3'b100;
    REQ = 2'b00;
    step();
    chk_total++;
    if ({B_UTIL, MST_RDBIT} !== 4'b0) $display("FAIL rd_release: got %b expected 0000", {B_UTIL, MST_RDBIT});
    else chk_pass++;
    B_ACK = '0; B_BUS_IN = '0; MST_RW = '0;
    step();
  endtask

  task automatic test_reset_mid_fwd();
    REQ = 2'b01;
    step();
    send_addr(16'h0812, 1'b0);
    step(); step(); step();
    chk_total++;
    if (B_UTIL !== 3'b010) $display("FAIL rst_pre_util: got %b expected 010", B_UTIL);
    else chk_pass++;
    RSTN = 1'b0;
    REQ  = 2'b11;
    #1;
    chk_total++;
    if ({GNT, B_UTIL, B_BUS_OUT} !== 6'b0) $display("FAIL rst_async: got %b expected 0", {GNT, B_UTIL, B_BUS_OUT});
    else chk_pass++;
    step();
    #2 RSTN = 1'b1;
    step();
    chk_total++;
    if (GNT !== 2'b01) $display("FAIL rst_rr_restart: got %b expected 01", GNT);
    else chk_pass++;
    REQ = 2'b00;
    step(); step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    chk_pass  = 0;
    chk_total = 0;
    test_reset();
    test_write_basic();
    test_back_to_back();
    test_decode_err();
    test_timeout();
    test_read_slave2();
    test_reset_mid_fwd();
    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
